// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM read arbiter.
// State encoding and address/count widths.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 11;

endpackage

// File: rtl/sdram_read_arbiter_rr_pick.sv
// Round-robin picker: first pending port after last_grant.
// Purely combinational; shared with the write arbiter.
module rr_pick #(
    parameter  int NUM_PORTS = 2,
    localparam int SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] pending,
    input  logic [SEL_W-1:0]     last_grant,
    output logic [SEL_W-1:0]     winner,
    output logic                 any
);

    int               cand;
    logic [SEL_W-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        cand   = 0;
        idx    = '0;
        // Search order: last_grant+1 ... last_grant (wraps)
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = (int'(last_grant) + i) % NUM_PORTS;
            idx  = SEL_W'(cand);
            if (!any && pending[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/sdram_read_arbiter.sv
// Round-robin arbiter for the shared SDRAM read channel.
// One pending slot per port; one burst in flight at a time.
module sdram_read_arbiter
    import sdram_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    parameter  int DATA_W    = 32,
    localparam int SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_PORTS-1:0]               req_start,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS-1:0][CNT_W-1:0]    req_cnt,
    output logic [NUM_PORTS-1:0]               req_valid,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]   req_data,
    output logic [NUM_PORTS-1:0]               req_done,
    output logic [NUM_PORTS-1:0]               req_drop,
    output logic [ADDR_W-1:0]                  read_addr,
    output logic [CNT_W-1:0]                   read_cnt,
    output logic                               read_start,
    input  logic                               read_valid,
    input  logic [DATA_W-1:0]                  read_data,
    input  logic                               read_done,
    output logic [SEL_W-1:0]                   sel,
    output logic                               busy
);

    arb_state_t                        state;
    arb_state_t                        state_nxt;
    logic [NUM_PORTS-1:0]              pending;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]  slot_addr;
    logic [NUM_PORTS-1:0][CNT_W-1:0]   slot_cnt;
    logic [SEL_W-1:0]                  last_grant;
    logic [SEL_W-1:0]                  winner;
    logic                              any;
    logic                              grant;
    logic                              finish;

    rr_pick #(
        .NUM_PORTS(NUM_PORTS)
    ) u_pick (
        .pending   (pending),
        .last_grant(last_grant),
        .winner    (winner),
        .any       (any)
    );

    assign grant  = (state == IDLE) && any;
    assign finish = (state == WAIT) && read_done;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slot
        logic              pend;
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  cnt;
        logic              drop;
        logic              issuing;

        assign issuing = (state == ISSUE) && (sel == SEL_W'(g));

        // A new request in the winner's ISSUE cycle refills the slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend <= 1'b0;
                addr <= '0;
                cnt  <= '0;
                drop <= 1'b0;
            end else begin
                drop <= 1'b0;
                if (req_start[g] && (!pend || issuing)) begin
                    pend <= 1'b1;
                    addr <= req_addr[g];
                    cnt  <= req_cnt[g];
                end else if (req_start[g]) begin
                    drop <= 1'b1;
                end else if (issuing) begin
                    pend <= 1'b0;
                end
            end
        end

        assign pending[g]   = pend;
        assign slot_addr[g] = addr;
        assign slot_cnt[g]  = cnt;
        assign req_drop[g]  = drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= SEL_W'(NUM_PORTS - 1);
            sel        <= '0;
            read_addr  <= '0;
            read_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                sel       <= winner;
                read_addr <= slot_addr[winner];
                read_cnt  <= slot_cnt[winner];
            end
            if (finish) begin
                last_grant <= sel;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        read_start = 1'b0;
        busy       = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_done   = '0;
        unique case (state)
            IDLE: begin
                if (any) state_nxt = ISSUE;
            end
            ISSUE: begin
                read_start = 1'b1;
                busy       = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                busy           = 1'b1;
                req_valid[sel] = read_valid;
                req_data[sel]  = read_data;
                req_done[sel]  = read_done;
                if (read_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
